daq_fifo_rst_sched: RTL and testbench



---
 rtl/daq_rst_pkg.sv | 22 ++
 rtl/daq_rst_rr_arb.sv | 28 ++
 rtl/daq_fifo_rst_sched.sv | 150 +++++++++++++++
 tb/tb_daq_fifo_rst_sched.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/daq_rst_pkg.sv
// Shared constants for the DAQ FIFO reset scheduler: state encoding,
// hold-counter width and grant index width.
package daq_rst_pkg;

    localparam int CNT_W = 8;
    localparam int GID_W = 3;

    localparam logic [2:0] ST_INIT_RST   = 3'd0;
    localparam logic [2:0] ST_INIT_PAUSE = 3'd1;
    localparam logic [2:0] ST_IDLE       = 3'd2;
    localparam logic [2:0] ST_DRAIN      = 3'd3;
    localparam logic [2:0] ST_RESET      = 3'd4;
    localparam logic [2:0] ST_PAUSE      = 3'd5;
    localparam logic [2:0] ST_ACK        = 3'd6;

    // States whose length is set by the hold counter.
    function automatic logic is_timed(input logic [2:0] st);
        return (st == ST_INIT_RST) || (st == ST_INIT_PAUSE) || (st == ST_DRAIN) ||
               (st == ST_RESET) || (st == ST_PAUSE);
    endfunction

endpackage

// File: rtl/daq_rst_rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module daq_rst_rr_arb
    import daq_rst_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req,
    input  logic [GID_W-1:0] ptr,
    output logic [GID_W-1:0] gnt,
    output logic             valid
);

    // Scan from ptr upward; the first hit wins.
    always_comb begin
        int idx;
        idx   = 0;
        gnt   = '0;
        valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                gnt   = GID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/daq_fifo_rst_sched.sv
// DAQ FIFO bank reset sequencer. Runs one full-bank reset after RST_N
// release, then serves reset requests round-robin: block writers, pulse
// FIFO_RST on the requested mask, wait for recovery, acknowledge.
// Build macro DAQ_RST_TMR_EN triplicates all sequential state with
// bitwise majority voting; without it a single copy is used.
//
// state       | meaning
// INIT_RST    | power-up reset of the whole bank
// INIT_PAUSE  | power-up recovery, writers blocked
// IDLE        | waiting for a request, writers free
// DRAIN       | writers blocked before reset
// RESET       | FIFO_RST driven with the latched mask
// PAUSE       | recovery after FIFO_RST drops
// ACK         | one-cycle completion pulse
module daq_fifo_rst_sched
    import daq_rst_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int NFIFO     = 7,
    parameter int DRAIN_CYC = 4,
    parameter int RST_CYC   = 10,
    parameter int PAUSE_CYC = 16
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [NREQ-1:0]        REQ,
    input  logic [NREQ*NFIFO-1:0]  TGT,
    output logic [NREQ-1:0]        ACK,
    output logic [GID_W-1:0]       GRANT_ID,
    output logic [NFIFO-1:0]       FIFO_RST,
    output logic                   WR_BLOCK,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [CNT_W-1:0]       RST_CNT
);

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [GID_W-1:0] ptr;
        logic [NFIFO-1:0] mask;
        logic [GID_W-1:0] gid;
        logic [CNT_W-1:0] rst_cnt;
        logic [NFIFO-1:0] fifo_rst;
        logic             wr_block;
        logic             busy;
        logic             done;
        logic [NREQ-1:0]  ack;
    } regs_t;

    localparam regs_t REGS_RST = '{cnt: '0, ptr: '0, mask: '0, gid: '0, rst_cnt: '0,
                                   fifo_rst: '1, wr_block: 1'b1, busy: 1'b1,
                                   done: 1'b0, ack: '0};

    logic [2:0]       st_q, st_d;
    regs_t            q, d;
    logic [GID_W-1:0] arb_gnt;
    logic             arb_valid;
    logic [NFIFO-1:0] tgt_sel;

    daq_rst_rr_arb #(.NREQ(NREQ)) u_arb (
        .req   (REQ),
        .ptr   (q.ptr),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    assign tgt_sel = TGT[int'(arb_gnt)*NFIFO +: NFIFO];

    // Next state plus every output precomputed from it, so outputs line up with their state.
    always_comb begin
        st_d  = st_q;
        d     = q;
        d.ack = '0;
        case (st_q)
            ST_INIT_RST:   if (q.cnt == CNT_W'(RST_CYC - 1))   st_d = ST_INIT_PAUSE;
            ST_INIT_PAUSE: if (q.cnt == CNT_W'(PAUSE_CYC - 1)) st_d = ST_IDLE;
            ST_IDLE: begin
                if (arb_valid) begin
                    d.gid  = arb_gnt;
                    d.mask = tgt_sel;
                    d.ptr  = (arb_gnt == GID_W'(NREQ - 1)) ? '0 : arb_gnt + 1'b1;
                    st_d   = (tgt_sel == '0) ? ST_ACK : ST_DRAIN;
                end
            end
            ST_DRAIN:      if (q.cnt == CNT_W'(DRAIN_CYC - 1)) st_d = ST_RESET;
            ST_RESET:      if (q.cnt == CNT_W'(RST_CYC - 1))   st_d = ST_PAUSE;
            ST_PAUSE:      if (q.cnt == CNT_W'(PAUSE_CYC - 1)) st_d = ST_ACK;
            ST_ACK:        st_d = ST_IDLE;
            default:       st_d = ST_INIT_RST;
        endcase

        d.cnt      = (st_d == st_q && is_timed(st_q)) ? q.cnt + 1'b1 : '0;
        d.fifo_rst = (st_d == ST_INIT_RST) ? '1 : ((st_d == ST_RESET) ? d.mask : '0);
        d.wr_block = (st_d != ST_IDLE);
        d.busy     = (st_d != ST_IDLE);
        d.done     = q.done | (st_d == ST_IDLE);
        if (st_d == ST_ACK) begin
            d.ack = NREQ'(1) << d.gid;
            // An empty mask touches no FIFO, so it is not counted as a reset.
            if (d.mask != '0 && q.rst_cnt != '1) d.rst_cnt = q.rst_cnt + 1'b1;
        end
    end

`ifdef DAQ_RST_TMR_EN
    logic [2:0] st_a, st_b, st_c;
    regs_t      q_a, q_b, q_c;

    assign st_q = (st_a & st_b) | (st_a & st_c) | (st_b & st_c);
    assign q    = regs_t'((q_a & q_b) | (q_a & q_c) | (q_b & q_c));

    // Three copies, each reloaded from the voted next value so an upset clears in one clock.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st_a <= ST_INIT_RST;
            st_b <= ST_INIT_RST;
            st_c <= ST_INIT_RST;
            q_a  <= REGS_RST;
            q_b  <= REGS_RST;
            q_c  <= REGS_RST;
        end else begin
            st_a <= st_d;
            st_b <= st_d;
            st_c <= st_d;
            q_a  <= d;
            q_b  <= d;
            q_c  <= d;
        end
    end
`else
    // Single copy of state, counters and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st_q <= ST_INIT_RST;
            q    <= REGS_RST;
        end else begin
            st_q <= st_d;
            q    <= d;
        end
    end
`endif

    assign ACK      = q.ack;
    assign GRANT_ID = q.gid;
    assign FIFO_RST = q.fifo_rst;
    assign WR_BLOCK = q.wr_block;
    assign BUSY     = q.busy;
    assign DONE     = q.done;
    assign RST_CNT  = q.rst_cnt;

endmodule

// File: tb/tb_daq_fifo_rst_sched.sv
// Bench for daq_fifo_rst_sched: behavioural model tracks each sequence as
// an elapsed-cycle offset and derives expected outputs from the phase lengths.
module tb_daq_fifo_rst_sched;

    localparam int NREQ      = 4;
    localparam int NFIFO     = 7;
    localparam int DRAIN_CYC = 4;
    localparam int RST_CYC   = 10;
    localparam int PAUSE_CYC = 16;
    localparam int SEQ_LEN   = DRAIN_CYC + RST_CYC + PAUSE_CYC;
    localparam int VW        = NFIFO + 3 + NREQ + 3 + 8;

    logic                  CLK = 1'b0;
    logic                  RST_N = 1'b0;
    logic [NREQ-1:0]       REQ = '0;
    logic [NREQ*NFIFO-1:0] TGT = '0;
    logic [NREQ-1:0]       ACK;
    logic [2:0]            GRANT_ID;
    logic [NFIFO-1:0]      FIFO_RST;
    logic                  WR_BLOCK, BUSY, DONE;
    logic [7:0]            RST_CNT;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    daq_fifo_rst_sched #(
        .NREQ(NREQ), .NFIFO(NFIFO), .DRAIN_CYC(DRAIN_CYC),
        .RST_CYC(RST_CYC), .PAUSE_CYC(PAUSE_CYC)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .TGT(TGT), .ACK(ACK),
        .GRANT_ID(GRANT_ID), .FIFO_RST(FIFO_RST), .WR_BLOCK(WR_BLOCK),
        .BUSY(BUSY), .DONE(DONE), .RST_CNT(RST_CNT)
    );

    logic [VW-1:0] obs_vec;
    logic [VW-1:0] exp_vec;
    assign obs_vec = {FIFO_RST, WR_BLOCK, BUSY, DONE, ACK, GRANT_ID, RST_CNT};

    // Reference model: init phase, idle, or a request sequence at offset m_t.
    typedef enum int {M_INIT, M_IDLE, M_SEQ} mode_t;
    mode_t            m_mode = M_INIT;
    int               m_t = 0, m_ptr = 0, m_gid = 0, m_rstcnt = 0;
    logic [NFIFO-1:0] m_mask = '0;
    logic             m_done = 1'b0;

    always @(posedge CLK or negedge RST_N) begin
        logic [NFIFO-1:0] f;
        logic [NREQ-1:0]  a;
        if (!RST_N) begin
            m_mode = M_INIT; m_t = 0; m_ptr = 0; m_gid = 0;
            m_rstcnt = 0; m_mask = '0; m_done = 1'b0;
        end else begin
            case (m_mode)
                M_INIT: begin
                    m_t++;
                    if (m_t >= RST_CYC + PAUSE_CYC) begin m_mode = M_IDLE; m_done = 1'b1; end
                end
                M_IDLE: begin
                    if (REQ != '0) begin
                        for (int i = 0; i < NREQ; i++) begin
                            if (REQ[(m_ptr + i) % NREQ]) begin m_gid = (m_ptr + i) % NREQ; break; end
                        end
                        m_mask = TGT[m_gid*NFIFO +: NFIFO];
                        m_ptr  = (m_gid + 1) % NREQ;
                        m_mode = M_SEQ;
                        m_t    = (m_mask == '0) ? SEQ_LEN : 0;
                        if (m_mask != '0 || m_mask == '0) begin end
                    end
                end
                default: begin
                    m_t++;
                    if (m_t > SEQ_LEN) begin m_mode = M_IDLE; m_t = 0; end
                end
            endcase
            if (m_mode == M_SEQ && m_t == SEQ_LEN && m_mask != '0 && m_rstcnt < 255) m_rstcnt++;
        end
        f = '0;
        a = '0;
        if (m_mode == M_INIT && m_t < RST_CYC) f = '1;
        if (m_mode == M_SEQ && m_t >= DRAIN_CYC && m_t < DRAIN_CYC + RST_CYC) f = m_mask;
        if (m_mode == M_SEQ && m_t == SEQ_LEN) a[m_gid] = 1'b1;
        exp_vec = {f, m_mode != M_IDLE, m_mode != M_IDLE, m_done, a, 3'(m_gid), 8'(m_rstcnt)};
    end

    task automatic test_reset();
        int n_rst = 0, n_pause = 0, first_done = -1;
        RST_N = 1'b0;
        REQ   = '0;
        TGT   = (NREQ*NFIFO)'($urandom);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (obs_vec !== {7'h7F, 1'b1, 1'b1, 1'b0, 4'b0000, 3'd0, 8'd0}) begin
            failures++; $display("FAIL reset_values got=%h exp=%h", obs_vec, {7'h7F, 3'b110, 4'b0, 3'd0, 8'd0});
        end
        @(posedge CLK);
        #2 RST_N = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL init_model cyc=%0d got=%h exp=%h", n, obs_vec, exp_vec);
            end
            if (FIFO_RST == 7'h7F) n_rst++;
            if (FIFO_RST == 7'h00 && WR_BLOCK && !DONE) n_pause++;
            if (DONE && first_done < 0) first_done = n;
        end
        checks++;
        if (n_rst != 10) begin failures++; $display("FAIL init_rst_len got=%0d exp=10", n_rst); end
        checks++;
        if (n_pause != 16) begin failures++; $display("FAIL init_pause_len got=%0d exp=16", n_pause); end
        checks++;
        if (first_done != 26) begin failures++; $display("FAIL init_done_cycle got=%0d exp=26", first_done); end
        checks++;
        if (WR_BLOCK !== 1'b0) begin failures++; $display("FAIL idle_wr_block got=%b exp=0", WR_BLOCK); end
    endtask

    task automatic test_single();
        int n_mask = 0, first_mask = -1;
        TGT = (NREQ*NFIFO)'($urandom);
        TGT[2*NFIFO +: NFIFO] = 7'h05;
        REQ = 4'b0100;
        for (int n = 1; n <= 34; n++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL single_model cyc=%0d got=%h exp=%h", n, obs_vec, exp_vec);
            end
            if (FIFO_RST == 7'h05) begin n_mask++; if (first_mask < 0) first_mask = n; end
            if (n == 1) begin
                checks++;
                if (WR_BLOCK !== 1'b1) begin failures++; $display("FAIL single_wr_block_rise got=%b exp=1", WR_BLOCK); end
            end
            if (n == 31) begin
                checks++;
                if (ACK !== 4'b0100) begin failures++; $display("FAIL single_ack got=%b exp=0100", ACK); end
                checks++;
                if (RST_CNT !== 8'd1) begin failures++; $display("FAIL single_rst_cnt got=%0d exp=1", RST_CNT); end
            end
            if (n == 32) begin
                REQ = '0;
                checks++;
                if (WR_BLOCK !== 1'b0) begin failures++; $display("FAIL single_wr_block_fall got=%b exp=0", WR_BLOCK); end
            end
        end
        checks++;
        if (n_mask != 10) begin failures++; $display("FAIL single_rst_len got=%0d exp=10", n_mask); end
        checks++;
        if (first_mask != 5) begin failures++; $display("FAIL single_rst_start got=%0d exp=5", first_mask); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] drop = '0;
        int got[$];
        for (int i = 0; i < NREQ; i++) TGT[i*NFIFO +: NFIFO] = NFIFO'($urandom_range(1, 127));
        REQ = 4'b1111;
        for (int n = 0; n < 160 && got.size() < 4; n++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL rr_model cyc=%0d got=%h exp=%h", n, obs_vec, exp_vec);
            end
            checks++;
            if ($countones(ACK) > 1) begin failures++; $display("FAIL rr_ack_onehot got=%b exp=at most one bit", ACK); end
            REQ  = REQ & ~drop;
            drop = ACK;
            for (int i = 0; i < NREQ; i++) if (ACK[i]) got.push_back(i);
        end
        @(negedge CLK);
        REQ = REQ & ~drop;
        checks++;
        if (got.size() != 4) begin failures++; $display("FAIL rr_ack_count got=%0d exp=4", got.size()); end
        // Requester 2 was the last one served, so the rotation starts at 3.
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] != (3 + i) % 4) begin
                failures++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, got[i], (3 + i) % 4);
            end
        end
    endtask

    task automatic test_zero_mask();
        TGT[1*NFIFO +: NFIFO] = '0;
        REQ = 4'b0010;
        for (int n = 1; n <= 3; n++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL zero_model cyc=%0d got=%h exp=%h", n, obs_vec, exp_vec);
            end
            if (n == 1) begin
                checks++;
                if ({ACK, WR_BLOCK, FIFO_RST, RST_CNT} !== {4'b0010, 1'b1, 7'h00, 8'd5}) begin
                    failures++; $display("FAIL zero_ack_cycle got=%b/%b/%h/%0d exp=0010/1/00/5", ACK, WR_BLOCK, FIFO_RST, RST_CNT);
                end
            end
            if (n == 2) begin
                REQ = '0;
                checks++;
                if ({ACK, WR_BLOCK, RST_CNT} !== {4'b0000, 1'b0, 8'd5}) begin
                    failures++; $display("FAIL zero_after got=%b/%b/%0d exp=0000/0/5", ACK, WR_BLOCK, RST_CNT);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] drop = '0;
        for (int n = 0; n < 840; n++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL random_model cyc=%0d got=%h exp=%h", n, obs_vec, exp_vec);
            end
            if (n >= 800) begin
                REQ = '0;
            end else begin
                REQ  = REQ & ~drop;
                drop = ACK;
                for (int i = 0; i < NREQ; i++) begin
                    if (!REQ[i]) begin
                        if ($urandom_range(0, 11) == 0) begin
                            TGT[i*NFIFO +: NFIFO] = ($urandom_range(0, 4) == 0) ? '0 : NFIFO'($urandom);
                            REQ[i] = 1'b1;
                        end
                    end else if (!drop[i]) begin
                        if ($urandom_range(0, 31) == 0) TGT[i*NFIFO +: NFIFO] = NFIFO'($urandom);
                        else if ($urandom_range(0, 149) == 0) REQ[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int first_ack = -1;
        TGT[0 +: NFIFO] = NFIFO'($urandom_range(1, 127));
        REQ = 4'b0001;
        for (int n = 1; n <= 8; n++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL midrst_pre_model cyc=%0d got=%h exp=%h", n, obs_vec, exp_vec);
            end
        end
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({FIFO_RST, DONE, RST_CNT} !== {7'h7F, 1'b0, 8'd0}) begin
            failures++; $display("FAIL midrst_async got=%h/%b/%0d exp=7f/0/0", FIFO_RST, DONE, RST_CNT);
        end
        @(posedge CLK);
        #2 RST_N = 1'b1;
        for (int n = 0; n < 70 && first_ack < 0; n++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL midrst_model cyc=%0d got=%h exp=%h", n, obs_vec, exp_vec);
            end
            if (ACK[0]) first_ack = n;
        end
        @(negedge CLK);
        REQ = '0;
        checks++;
        if (first_ack != 57) begin failures++; $display("FAIL midrst_pending_ack got=%0d exp=57", first_ack); end
    endtask

`ifdef DAQ_RST_TMR_EN
    task automatic test_tmr();
        TGT[2*NFIFO +: NFIFO] = 7'h11;
        REQ = 4'b0100;
        for (int n = 1; n <= 34; n++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL tmr_model cyc=%0d got=%h exp=%h", n, obs_vec, exp_vec);
            end
            if (n == 20) begin
                force dut.st_a = 3'd7;
                #1 release dut.st_a;
                checks++;
                if (obs_vec !== exp_vec) begin
                    failures++; $display("FAIL tmr_upset_outputs got=%h exp=%h", obs_vec, exp_vec);
                end
            end
            if (n == 21) begin
                checks++;
                if (dut.st_a !== 3'd5) begin failures++; $display("FAIL tmr_scrub got=%0d exp=5", dut.st_a); end
            end
            if (n == 32) REQ = '0;
        end
    endtask
`endif

    task automatic test_saturation();
        int extra = 0;
        TGT[0 +: NFIFO] = NFIFO'(1);
        REQ = 4'b0001;
        for (int n = 0; n < 10000 && extra < 2; n++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL sat_model cyc=%0d got=%h exp=%h", n, obs_vec, exp_vec);
            end
            if (ACK[0] && exp_vec[7:0] == 8'd255) extra++;
        end
        REQ = '0;
        checks++;
        if (RST_CNT !== 8'd255) begin failures++; $display("FAIL sat_value got=%0d exp=255", RST_CNT); end
        checks++;
        if (extra < 2) begin failures++; $display("FAIL sat_timeout got=%0d exp=2 acks at 255", extra); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_mask();
        test_random();
        test_reset_mid();
`ifdef DAQ_RST_TMR_EN
        test_tmr();
`endif
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
